prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Run controller for the single-cycle RISC core on the labkit. It takes the debounced program-request buttons and arbitrates them by fixed priority. For the chosen program it drives the core's active-high `cpu_reset` and the regfile `program_selector` through a reset / copy / run sequence. While the program runs it counts cycles until the core signals halt or a timeout expires, then holds the result for the display.

## Interface
- `RESET_CYCLES`, default 2: cycles `cpu_reset` is held with selector 0 before the copy; legal range ≥1.
- `COPY_CYCLES`, default 4: cycles the selector is held non-zero, with `cpu_reset` high, so the regfile can copy the program; legal range ≥1.
- `TIMEOUT`, default 32'd25_000_000: maximum RUN cycles (1 s at 25 MHz); legal range ≥1.
- `clock`  input  1  system clock, the 25 MHz labkit clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `req`  input  4  debounced request levels. Bit0 = fib (program 1), bit1 = sort (2), bit2 = save (3), bit3 = load (4).
- `abort`  input  1  synchronous, active-high; cancels any sequence.
- `halt`  input  1  core-done indication, sampled only in RUN.
- `cpu_reset`  output  1  active-high reset to the pc, regfile and mem blocks.
- `program_selector`  output  32  selector to the regfile; zero-extended program number.
- `busy`  output  1  high in RESET, COPY and RUN.
- `done`  output  1  high in DONE.
- `timed_out`  output  1  high in DONE when the run ended by timeout.
- `cycle_count`  output  32  RUN cycles of the current or last run.

## Operation
- States: IDLE, RESET, COPY, RUN, DONE; encoded in 3 bits. All outputs are registered.
- Edge detect: `req_prev` is registered each cycle. A launch needs `req & ~req_prev` ≠ 0.
- `req_prev` resets to 4'b1111, so a button held through reset release never launches.
- Arbitration: the lowest set bit of the rising-edge vector wins. The winning program number (1–4) is latched into `active_prog` (3 bits).
- IDLE or DONE with a rising edge → RESET. This clears `cycle_count`, `done` and `timed_out`, and loads a phase counter with `RESET_CYCLES-1`.
- RESET: `cpu_reset`=1, selector=0. When the phase counter reaches 0 → COPY, and the phase counter loads `COPY_CYCLES-1`.
- COPY: `cpu_reset`=1, selector=`active_prog`. When the phase counter reaches 0 → RUN.
- RUN: `cpu_reset`=0, selector=0, `cycle_count` +1 every cycle, including the exit cycle.
  - `halt`=1 → DONE with `timed_out`=0.
  - Otherwise, `cycle_count`==`TIMEOUT-1` → DONE with `timed_out`=1. In that case `cycle_count` ends at `TIMEOUT`.
- DONE: `cpu_reset`=0 and selector=0, so register state stays visible to the display. `cycle_count` is frozen. The block waits for a new rising edge.
- `abort`=1 in any state → IDLE next cycle. It has priority over every other transition. `cycle_count` is kept; `done` and `timed_out` clear.
- IDLE: `cpu_reset`=1, selector=0; the core is held in reset.
- Rising edges seen in RESET, COPY or RUN are dropped, not queued. `req_prev` still updates, so a held button does not relaunch later.
- `halt` outside RUN is ignored.

## Timing
- Reset values: state IDLE, `cpu_reset`=1, `program_selector`=0, `busy`=0, `done`=0, `timed_out`=0, `cycle_count`=0, `active_prog`=0, `req_prev`=4'b1111.
- Asynchronous assertion of `reset` forces these values immediately. This applies mid-sequence as well.
- Launch latency: an edge sampled at edge t gives outputs in RESET from t+1.
- Default phase lengths: RESET lasts 2 cycles. COPY follows at t+3 with the selector valid for exactly 4 cycles. RUN starts at t+7.
- `halt` sampled at RUN edge k → `done`=1 from k+1. `cycle_count` then equals the number of RUN cycles including the halt cycle.
- If `halt` and the timeout condition occur in the same cycle, halt wins and `timed_out`=0.
- A launch from DONE is accepted with the same latency as from IDLE.
- If `abort` and a rising edge occur in the same cycle, the result is IDLE and no launch.

## Test plan
- Reset release with `req`=4'b0010 held → no launch. Release, then raise bit1 → selector=2 for exactly 4 cycles with `cpu_reset`=1, then `cpu_reset`=0 at the 7th cycle after the edge.
- `req` rises 4'b0110 simultaneously → selector=2 (bit1 wins over bit2); `active_prog`=2.
- RUN, `halt` pulsed on the 10th RUN cycle → `done`=1, `timed_out`=0, `cycle_count`=10 and held; `busy`=0.
- `TIMEOUT`=16, `halt` never asserted → DONE after 16 RUN cycles, `timed_out`=1, `cycle_count`=16. `halt` and timeout coinciding on cycle 16 → `timed_out`=0.
- Bit0 edge during RUN → ignored, `active_prog` unchanged. A new bit3 edge in DONE → RESET next cycle, `cycle_count`=0, then selector=4 in COPY.
- `abort` in COPY → IDLE, `cpu_reset`=1, selector=0 next cycle. Async `reset` low mid-RUN → all outputs at reset values with no clock edge.

Source files
------------

// File: rtl/prog_sequencer.sv
// Run controller for the labkit RISC core: picks a program from button edges, then
// sequences cpu_reset / program_selector through reset, copy and run, and times the run.
module prog_sequencer #(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned COPY_CYCLES  = 4,
  parameter logic [31:0] TIMEOUT      = 32'd25_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic        abort,
  input  logic        halt,
  output logic        cpu_reset,
  output logic [31:0] program_selector,
  output logic        busy,
  output logic        done,
  output logic        timed_out,
  output logic [31:0] cycle_count,
  output logic [2:0]  dbg_state,
  output logic [2:0]  dbg_active_prog
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_COPY  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [31:0] RESET_LOAD = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] COPY_LOAD  = 32'(COPY_CYCLES - 1);
  localparam logic [31:0] LAST_RUN   = TIMEOUT - 32'd1;

  state_t      r_state;
  logic [3:0]  r_req_prev;
  logic [2:0]  r_active_prog;
  logic [31:0] r_phase;
  logic [31:0] r_cycle_count;
  logic        r_cpu_reset;
  logic [2:0]  r_sel;
  logic        r_busy;
  logic        r_done;
  logic        r_timed_out;

  logic [3:0]  w_rise;
  logic [2:0]  w_win;

  assign w_rise = req & ~r_req_prev;

  // Fixed priority: lowest rising bit wins, program number is bit index + 1.
  always_comb begin
    w_win = 3'd0;
    if (w_rise[0])      w_win = 3'd1;
    else if (w_rise[1]) w_win = 3'd2;
    else if (w_rise[2]) w_win = 3'd3;
    else if (w_rise[3]) w_win = 3'd4;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_req_prev    <= 4'b1111;
      r_active_prog <= 3'd0;
      r_phase       <= 32'd0;
      r_cycle_count <= 32'd0;
      r_cpu_reset   <= 1'b1;
      r_sel         <= 3'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timed_out   <= 1'b0;
    end else begin
      // Edge history always advances, so edges swallowed while busy never relaunch.
      r_req_prev <= req;
      if (abort) begin
        r_state     <= S_IDLE;
        r_cpu_reset <= 1'b1;
        r_sel       <= 3'd0;
        r_busy      <= 1'b0;
        r_done      <= 1'b0;
        r_timed_out <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (|w_rise) begin
              r_state       <= S_RESET;
              r_active_prog <= w_win;
              r_phase       <= RESET_LOAD;
              r_cycle_count <= 32'd0;
              r_cpu_reset   <= 1'b1;
              r_sel         <= 3'd0;
              r_busy        <= 1'b1;
              r_done        <= 1'b0;
              r_timed_out   <= 1'b0;
            end
          end
          S_RESET: begin
            if (r_phase == 32'd0) begin
              r_state <= S_COPY;
              r_phase <= COPY_LOAD;
              r_sel   <= r_active_prog;
            end else begin
              r_phase <= r_phase - 32'd1;
            end
          end
          S_COPY: begin
            if (r_phase == 32'd0) begin
              r_state     <= S_RUN;
              r_cpu_reset <= 1'b0;
              r_sel       <= 3'd0;
            end else begin
              r_phase <= r_phase - 32'd1;
            end
          end
          S_RUN: begin
            // The exit cycle is counted too, so a timeout leaves the count at TIMEOUT.
            r_cycle_count <= r_cycle_count + 32'd1;
            if (halt) begin
              r_state     <= S_DONE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_timed_out <= 1'b0;
            end else if (r_cycle_count == LAST_RUN) begin
              r_state     <= S_DONE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_timed_out <= 1'b1;
            end
          end
          default: begin
            r_state     <= S_IDLE;
            r_cpu_reset <= 1'b1;
            r_sel       <= 3'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timed_out <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cpu_reset        = r_cpu_reset;
  assign program_selector = {29'd0, r_sel};
  assign busy             = r_busy;
  assign done             = r_done;
  assign timed_out        = r_timed_out;
  assign cycle_count      = r_cycle_count;
  assign dbg_state        = r_state;
  assign dbg_active_prog  = r_active_prog;

endmodule

// File: tb/tb_prog_sequencer.sv
// Randomized bench for prog_sequencer: launch timelines are predicted from phase
// lengths and the priority rule, run lengths from the halt/timeout rule.
module tb_prog_sequencer;

  localparam int RC = 2;
  localparam int CC = 4;
  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic        abort;
  logic        halt;
  logic        cpu_reset;
  logic [31:0] program_selector;
  logic        busy;
  logic        done;
  logic        timed_out;
  logic [31:0] cycle_count;
  logic [2:0]  dbg_state;
  logic [2:0]  dbg_active_prog;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_cnt;
  int          model_prog;

  prog_sequencer #(
    .RESET_CYCLES(RC),
    .COPY_CYCLES (CC),
    .TIMEOUT     (32'(TO))
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req             (req),
    .abort           (abort),
    .halt            (halt),
    .cpu_reset       (cpu_reset),
    .program_selector(program_selector),
    .busy            (busy),
    .done            (done),
    .timed_out       (timed_out),
    .cycle_count     (cycle_count),
    .dbg_state       (dbg_state),
    .dbg_active_prog (dbg_active_prog)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic cr, input logic [31:0] sel,
                           input logic b, input logic d, input logic t, input logic [31:0] cnt);
    check({tag, ".cpu_reset"}, 32'(cpu_reset), 32'(cr));
    check({tag, ".selector"}, program_selector, sel);
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(d));
    check({tag, ".timed_out"}, 32'(timed_out), 32'(t));
    check({tag, ".cycle_count"}, cycle_count, cnt);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int lowest_prog(input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[i]) return i + 1;
    return 0;
  endfunction

  // driver + model: one full launch; halt_at outside 1..TO means never halt
  task automatic launch(input logic [3:0] bits, input int halt_at, input bit glitch);
    int  n;
    bit  ended;
    logic exp_to;
    req = 4'b0000;
    tick();
    model_prog = lowest_prog(bits);
    req = bits;
    tick();
    req = 4'b0000;
    model_cnt = 32'd0;
    for (int k = 1; k <= RC; k++) begin
      check_out("reset_phase", 1'b1, 32'd0, 1'b1, 1'b0, 1'b0, model_cnt);
      check("reset_phase.prog", 32'(dbg_active_prog), 32'(model_prog));
      halt = 1'($urandom_range(0, 1));
      tick();
    end
    for (int k = 1; k <= CC; k++) begin
      check_out("copy_phase", 1'b1, 32'(model_prog), 1'b1, 1'b0, 1'b0, model_cnt);
      halt = 1'($urandom_range(0, 1));
      tick();
    end
    n = 0;
    ended = 1'b0;
    while (!ended && n < TO + 4) begin
      n++;
      check_out("run_phase", 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'(n - 1));
      check("run_phase.prog", 32'(dbg_active_prog), 32'(model_prog));
      halt = (n == halt_at);
      req = (glitch && n == 3 && (halt_at <= 0 || halt_at > 5)) ? 4'b0001 : 4'b0000;
      tick();
      if (n == halt_at || n == TO) ended = 1'b1;
    end
    if (!ended) check("run_bound", 32'(n), 32'(TO));
    halt = 1'b0;
    req = 4'b0000;
    exp_to = (n != halt_at);
    exp_q.push_back(32'(n));
    model_cnt = exp_q.pop_front();
    check_out("done_phase", 1'b0, 32'd0, 1'b0, 1'b1, exp_to, model_cnt);
    check("done_phase.prog", 32'(dbg_active_prog), 32'(model_prog));
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check_out("done_hold", 1'b0, 32'd0, 1'b0, 1'b1, exp_to, model_cnt);
  endtask

  task automatic abort_now();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_out("after_abort", 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, model_cnt);
  endtask

  initial begin
    req = 4'b0010;
    abort = 1'b0;
    halt = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check_out("por", 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    check("por.prog", 32'(dbg_active_prog), 32'd0);
    tick();
    reset = 1'b1;
    model_cnt = 32'd0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out("held_button", 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    end

    launch(4'b0010, 10, 1'b0);
    launch(4'b0110, 0, 1'b1);
    launch(4'b1000, TO, 1'b0);
    abort_now();

    // abort during copy
    req = 4'b0001;
    tick();
    req = 4'b0000;
    repeat (RC + 1) tick();
    check_out("copy_pre_abort", 1'b1, 32'd1, 1'b1, 1'b0, 1'b0, 32'd0);
    model_cnt = 32'd0;
    abort_now();

    // abort coinciding with an edge: no launch now or later
    req = 4'b0100;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_out("abort_edge", 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, model_cnt);
    tick();
    check_out("abort_edge_late", 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, model_cnt);

    for (int it = 0; it < 14; it++) begin
      launch(4'($urandom_range(1, 15)), $urandom_range(0, 20), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) abort_now();
    end

    // asynchronous reset in the middle of a run
    req = 4'b0000;
    tick();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    repeat (RC + CC + 2) tick();
    check("mid_run.busy", 32'(busy), 32'd1);
    #3 reset = 1'b0;
    #1;
    check_out("async_reset", 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    check("async_reset.prog", 32'(dbg_active_prog), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check_out("post_reset", 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
